// File: rtl/vga_timing_core.sv
// VGA raster timing generator: pixel/line counters with zero-skew registered
// sync, visible-area flag and single-cycle line/frame/vblank event strobes.
module vga_timing_core #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_BOTTOM    = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_TOP       = 33,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int unsigned CW      = 10;
    localparam int unsigned FCW     = 8;
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS_END  = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS_END  = CW'(V_DISPLAY);
    localparam logic [CW-1:0] V_VIS_LAST = CW'(V_DISPLAY - 1);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_DISPLAY + V_BOTTOM);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic          h_wrap_c;
    logic          v_wrap_c;
    logic          vis_last_line_c;
    logic [CW-1:0] hpos_nxt_c;
    logic [CW-1:0] vpos_nxt_c;
    logic          hsync_nxt_c;
    logic          vsync_nxt_c;
    logic          display_nxt_c;

    // Next raster position; level outputs are decoded from it so that the
    // registered levels line up with the registered counters in the same cycle.
    always_comb begin
        h_wrap_c        = 1'b0;
        v_wrap_c        = 1'b0;
        vis_last_line_c = 1'b0;
        hpos_nxt_c      = hpos;
        vpos_nxt_c      = vpos;
        hsync_nxt_c     = ~SYNC_ACTIVE;
        vsync_nxt_c     = ~SYNC_ACTIVE;
        display_nxt_c   = 1'b0;

        h_wrap_c        = (hpos == H_LAST);
        v_wrap_c        = (vpos == V_LAST);
        vis_last_line_c = (vpos == V_VIS_LAST);

        if (h_wrap_c) begin
            hpos_nxt_c = '0;
            vpos_nxt_c = v_wrap_c ? '0 : vpos + CW'(1);
        end else begin
            hpos_nxt_c = hpos + CW'(1);
        end

        if (hpos_nxt_c >= HS_FIRST && hpos_nxt_c <= HS_LAST) begin
            hsync_nxt_c = SYNC_ACTIVE;
        end
        if (vpos_nxt_c >= VS_FIRST && vpos_nxt_c <= VS_LAST) begin
            vsync_nxt_c = SYNC_ACTIVE;
        end
        display_nxt_c = (hpos_nxt_c < H_VIS_END) && (vpos_nxt_c < V_VIS_END);
    end

    // Counters and levels advance only with ce; strobes are rewritten every
    // clk so they always drop after one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos         <= '0;
            vpos         <= '0;
            frame_count  <= '0;
            hsync        <= ~SYNC_ACTIVE;
            vsync        <= ~SYNC_ACTIVE;
            display_on   <= 1'b1;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            line_start   <= ce & h_wrap_c;
            frame_start  <= ce & h_wrap_c & v_wrap_c;
            vblank_start <= ce & h_wrap_c & vis_last_line_c;
            if (ce) begin
                hpos       <= hpos_nxt_c;
                vpos       <= vpos_nxt_c;
                hsync      <= hsync_nxt_c;
                vsync      <= vsync_nxt_c;
                display_on <= display_nxt_c;
                if (h_wrap_c && v_wrap_c) begin
                    frame_count <= frame_count + FCW'(1);
                end
            end
        end
    end

endmodule
